// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus arbiter.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_CONNECT    = 3'd3,
    ST_RELEASE    = 3'd4
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Minimum number of serial select bits able to address ns slaves.
  function automatic int sel_bits(input int ns);
    return (ns <= 2) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/bus_arbiter_n_rr_picker.sv
// Combinational winner selection: lowest index (fixed) or first requester above last (round-robin).
module rr_picker #(
  parameter int NM = 4,
  parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [LW-1:0] i_last,
  input  logic          i_mode,
  output logic [LW-1:0] o_idx,
  output logic          o_valid
);

  int w_j;

  // Scan from the farthest candidate down so the nearest requester is assigned last.
  always_comb begin
    o_idx = '0;
    w_j   = 0;
    if (i_mode) begin
      for (int k = NM; k >= 1; k--) begin
        w_j = (int'(i_last) + k) % NM;
        if (i_req[w_j]) o_idx = LW'(w_j);
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = LW'(i);
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/bus_arbiter_n.sv
// NM-master / NS-slave serial bus arbiter: grants one owner, decodes a serial slave select,
// waits for slave ready (with timeout), then routes the owner's lanes to the chosen slave.
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int NM      = 4,
  parameter int NS      = 4,
  parameter int SEL_W   = sel_bits(NS),
  parameter int MODE    = MODE_RR,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NM-1:0] m_request,
  input  logic [NM-1:0] m_address,
  input  logic [NM-1:0] m_address_valid,
  input  logic [NM-1:0] m_data,
  input  logic [NM-1:0] m_valid,
  input  logic [NM-1:0] m_write_en,
  output logic [NM-1:0] m_available,
  output logic [NM-1:0] m_data_out,
  output logic [NM-1:0] m_valid_in,
  output logic [NM-1:0] m_error,
  input  logic [NS-1:0] s_ready,
  input  logic [NS-1:0] s_data_in,
  input  logic [NS-1:0] s_valid_out,
  output logic [NS-1:0] s_address,
  output logic [NS-1:0] s_data,
  output logic [NS-1:0] s_valid,
  output logic [NS-1:0] s_write_en,
  output logic [NS-1:0] s_bus_ready,
  output logic [2:0]    state
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = $clog2(SEL_W + 1);

  state_t           r_state;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_last;
  logic [SEL_W-1:0] r_sel;
  logic [BW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_error;

  logic [OW-1:0]    w_pick_idx;
  logic             w_pick_valid;
  logic             w_mode;
  logic             w_req_own, w_addr_own, w_addr_v_own, w_data_own, w_valid_own, w_we_own;
  logic             w_ready_sel, w_sdin_sel, w_svo_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic             w_active, w_conn;

  assign w_mode = (MODE == MODE_RR);

  rr_picker #(.NM(NM), .LW(OW)) u_picker (
    .i_req   (m_request),
    .i_last  (r_last),
    .i_mode  (w_mode),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Owner-side and selected-slave-side lanes, flattened to scalars.
  always_comb begin
    w_req_own    = 1'b0;
    w_addr_own   = 1'b0;
    w_addr_v_own = 1'b0;
    w_data_own   = 1'b0;
    w_valid_own  = 1'b0;
    w_we_own     = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (r_owner == OW'(i)) begin
        w_req_own    = m_request[i];
        w_addr_own   = m_address[i];
        w_addr_v_own = m_address_valid[i];
        w_data_own   = m_data[i];
        w_valid_own  = m_valid[i];
        w_we_own     = m_write_en[i];
      end
    end
    w_ready_sel = 1'b0;
    w_sdin_sel  = 1'b0;
    w_svo_sel   = 1'b0;
    for (int j = 0; j < NS; j++) begin
      if (r_sel == SEL_W'(j)) begin
        w_ready_sel = s_ready[j];
        w_sdin_sel  = s_data_in[j];
        w_svo_sel   = s_valid_out[j];
      end
    end
  end

  assign w_sel_next = (r_sel << 1) | SEL_W'(w_addr_own);

  // The select decision is taken on the cycle the last select bit arrives.
  // m_error is registered, so the pulse coincides with the single RELEASE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_last    <= OW'(NM - 1);
      r_sel     <= '0;
      r_bit_cnt <= '0;
      r_tmo_cnt <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_owner   <= w_pick_idx;
            r_sel     <= '0;
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
            r_state   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (!w_req_own) begin
            r_state <= ST_RELEASE;
          end else if (w_addr_v_own) begin
            r_sel     <= w_sel_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BW'(SEL_W - 1)) begin
              if (int'(w_sel_next) >= NS) begin
                r_error <= 1'b1;
                r_state <= ST_RELEASE;
              end else begin
                r_state <= ST_WAIT_READY;
              end
            end
          end
        end
        ST_WAIT_READY: begin
          if (!w_req_own) begin
            r_state <= ST_RELEASE;
          end else if (w_ready_sel) begin
            r_state <= ST_CONNECT;
          end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_state <= ST_RELEASE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_CONNECT: begin
          if (!w_req_own) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == ST_SELECT) || (r_state == ST_WAIT_READY) || (r_state == ST_CONNECT);
  assign w_conn   = (r_state == ST_CONNECT);

  always_comb begin
    m_available = '0;
    m_data_out  = '0;
    m_valid_in  = '0;
    m_error     = '0;
    s_address   = '0;
    s_data      = '0;
    s_valid     = '0;
    s_write_en  = '0;
    s_bus_ready = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_owner == OW'(i)) begin
        m_available[i] = w_active;
        m_error[i]     = r_error;
        m_data_out[i]  = w_conn & w_sdin_sel;
        m_valid_in[i]  = w_conn & w_svo_sel;
      end
    end
    for (int j = 0; j < NS; j++) begin
      if (r_sel == SEL_W'(j)) begin
        s_address[j]   = w_conn & w_addr_own;
        s_data[j]      = w_conn & w_data_own;
        s_valid[j]     = w_conn & (w_valid_own | w_addr_v_own);
        s_write_en[j]  = w_conn & w_we_own;
        s_bus_ready[j] = w_conn;
      end
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a round-robin NS=4 instance and a fixed-priority NS=3 instance
// share stimulus; a transaction-level model predicts owners, errors, timing and routed streams.
module tb_bus_arbiter_n;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] m_request, m_address, m_address_valid, m_data, m_valid, m_write_en;
  logic [3:0] s_ready, s_data_in, s_valid_out;

  logic [3:0] a_m_available, a_m_data_out, a_m_valid_in, a_m_error;
  logic [3:0] a_s_address, a_s_data, a_s_valid, a_s_write_en, a_s_bus_ready;
  logic [2:0] a_state;
  logic [3:0] b_m_available, b_m_data_out, b_m_valid_in, b_m_error;
  logic [2:0] b_s_address, b_s_data, b_s_valid, b_s_write_en, b_s_bus_ready;
  logic [2:0] b_state;

  logic use_b;
  logic [3:0] o_avail, o_dout, o_vin, o_err, o_saddr, o_sdata, o_svalid, o_swe, o_sbr;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 3;
  int mode_cur = 1;
  logic [7:0] exp_q[$];

  bus_arbiter_n #(.NM(4), .NS(4), .SEL_W(2), .MODE(1), .TIMEOUT(TIMEOUT)) dut_a (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address(m_address), .m_address_valid(m_address_valid),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en),
    .m_available(a_m_available), .m_data_out(a_m_data_out), .m_valid_in(a_m_valid_in),
    .m_error(a_m_error),
    .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out),
    .s_address(a_s_address), .s_data(a_s_data), .s_valid(a_s_valid),
    .s_write_en(a_s_write_en), .s_bus_ready(a_s_bus_ready), .state(a_state)
  );

  bus_arbiter_n #(.NM(4), .NS(3), .SEL_W(2), .MODE(0), .TIMEOUT(TIMEOUT)) dut_b (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address(m_address), .m_address_valid(m_address_valid),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en),
    .m_available(b_m_available), .m_data_out(b_m_data_out), .m_valid_in(b_m_valid_in),
    .m_error(b_m_error),
    .s_ready(s_ready[2:0]), .s_data_in(s_data_in[2:0]), .s_valid_out(s_valid_out[2:0]),
    .s_address(b_s_address), .s_data(b_s_data), .s_valid(b_s_valid),
    .s_write_en(b_s_write_en), .s_bus_ready(b_s_bus_ready), .state(b_state)
  );

  always_comb begin
    if (use_b) begin
      o_avail = b_m_available; o_dout = b_m_data_out; o_vin = b_m_valid_in; o_err = b_m_error;
      o_saddr = {1'b0, b_s_address}; o_sdata = {1'b0, b_s_data}; o_svalid = {1'b0, b_s_valid};
      o_swe = {1'b0, b_s_write_en}; o_sbr = {1'b0, b_s_bus_ready}; o_state = b_state;
    end else begin
      o_avail = a_m_available; o_dout = a_m_data_out; o_vin = a_m_valid_in; o_err = a_m_error;
      o_saddr = a_s_address; o_sdata = a_s_data; o_svalid = a_s_valid;
      o_swe = a_s_write_en; o_sbr = a_s_bus_ready; o_state = a_state;
    end
  end

  // Clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule.
  function automatic int exp_winner(input logic [3:0] req, input int last, input int mode);
    int w;
    bit found;
    w = 0;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      int cand;
      cand = (mode == 0) ? k : (last + 1 + k) % 4;
      if (!found && req[cand]) begin
        w = cand;
        found = 1;
      end
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic noise();
    m_address       = 4'($urandom);
    m_address_valid = 4'($urandom);
    m_data          = 4'($urandom);
    m_valid         = 4'($urandom);
    m_write_en      = 4'($urandom);
    s_ready         = 4'($urandom);
    s_data_in       = 4'($urandom);
    s_valid_out     = 4'($urandom);
  endtask

  task automatic start_txn(input logic [3:0] req, output int o);
    o = exp_winner(req, m_last, mode_cur);
    noise();
    m_request = req;
    step();
    check("grant_state", 32'(o_state), 1);
    check("grant_onehot", 32'(o_avail), 1 << o);
    check("grant_no_err", 32'(o_err), 0);
  endtask

  task automatic send_sel(input int o, input int sel);
    for (int b = 1; b >= 0; b--) begin
      noise();
      m_address[o]       = sel[b];
      m_address_valid[o] = 1'b1;
      #1;
      check("sel_not_forwarded", 32'(o_sbr | o_svalid | o_saddr), 0);
      step();
    end
  endtask

  task automatic finish_release(input int o);
    m_request[o] = 1'b0;
    step();
    check("idle_state", 32'(o_state), 0);
    check("idle_avail", 32'(o_avail), 0);
    check("idle_err", 32'(o_err), 0);
    m_last = o;
  endtask

  // abort_at: 0 none, 1 drop in SELECT, 2 drop in WAIT_READY, 3 reset during CONNECT
  task automatic run_txn(input logic [3:0] req, input int sel, input logic wr,
                         input logic [7:0] wbyte, input logic [7:0] rbyte,
                         input int delay, input int abort_at);
    int o;
    int ns;
    logic [7:0] ow, orr;
    logic ab, av, mv, sv;
    bit did_reset;
    ns = use_b ? 3 : 4;
    did_reset = 0;
    start_txn(req, o);
    if (abort_at == 1) begin
      noise();
      m_request[o] = 1'b0;
      step();
      check("abort_sel_state", 32'(o_state), 4);
      check("abort_sel_err", 32'(o_err), 0);
      finish_release(o);
    end else begin
      send_sel(o, sel);
      if (sel >= ns) begin
        check("badsel_state", 32'(o_state), 4);
        check("badsel_err", 32'(o_err), 1 << o);
        check("badsel_avail", 32'(o_avail), 0);
        finish_release(o);
      end else begin
        check("wait_state", 32'(o_state), 2);
        check("wait_err", 32'(o_err), 0);
        for (int d = 0; d < delay; d++) begin
          noise();
          s_ready[sel] = 1'b0;
          step();
          check("wait_hold", 32'(o_state), 2);
        end
        if (abort_at == 2) begin
          noise();
          s_ready[sel] = 1'b0;
          m_request[o] = 1'b0;
          step();
          check("abort_wait_state", 32'(o_state), 4);
          check("abort_wait_err", 32'(o_err), 0);
          finish_release(o);
        end else begin
          noise();
          s_ready[sel] = 1'b1;
          step();
          check("conn_state", 32'(o_state), 3);
          exp_q.push_back(wbyte);
          exp_q.push_back(rbyte);
          ow  = '0;
          orr = '0;
          for (int i = 7; i >= 0; i--) begin
            noise();
            ab = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            mv = 1'($urandom_range(0, 1));
            sv = 1'($urandom_range(0, 1));
            m_address[o] = ab; m_address_valid[o] = av; m_data[o] = wbyte[i];
            m_valid[o] = mv; m_write_en[o] = wr;
            s_data_in[sel] = rbyte[i]; s_valid_out[sel] = sv;
            if (i == 0) m_request[o] = 1'b0;
            #1;
            check("rt_bus_ready", 32'(o_sbr), 1 << sel);
            check("rt_valid", 32'(o_svalid), (mv | av) ? (1 << sel) : 0);
            check("rt_addr", 32'(o_saddr), ab ? (1 << sel) : 0);
            check("rt_we", 32'(o_swe), wr ? (1 << sel) : 0);
            check("rt_sdata_others", 32'(o_sdata & ~(4'd1 << sel)), 0);
            check("rt_vin", 32'(o_vin), sv ? (1 << o) : 0);
            check("rt_dout_others", 32'(o_dout & ~(4'd1 << o)), 0);
            check("rt_avail", 32'(o_avail), 1 << o);
            ow  = {ow[6:0], o_sdata[sel]};
            orr = {orr[6:0], o_dout[o]};
            if (abort_at == 3) begin
              reset = 1'b0;
              #1;
              check("rst_state", 32'(o_state), 0);
              check("rst_outputs", 32'(o_avail | o_dout | o_vin | o_err), 0);
              check("rst_slaves", 32'(o_saddr | o_sdata | o_svalid | o_swe | o_sbr), 0);
              did_reset = 1;
              break;
            end
            step();
          end
          if (did_reset) begin
            exp_q.delete();
            m_request = '0;
            step();
            reset  = 1'b1;
            m_last = 3;
          end else begin
            check("rel_state", 32'(o_state), 4);
            check("rel_outputs", 32'(o_avail | o_err | o_sbr | o_sdata | o_vin), 0);
            check("wr_stream", 32'(ow), 32'(exp_q.pop_front()));
            check("rd_stream", 32'(orr), 32'(exp_q.pop_front()));
            finish_release(o);
          end
        end
      end
    end
  endtask

  task automatic run_timeout(input logic [3:0] req, input int sel, input bit drop);
    int o;
    int n;
    start_txn(req, o);
    send_sel(o, sel);
    check("tmo_wait_state", 32'(o_state), 2);
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      noise();
      s_ready[sel] = 1'b0;
      if (drop && c == TIMEOUT) m_request[o] = 1'b0;
      step();
      n = c;
      if (o_state != 3'd2) break;
    end
    check("tmo_len", n, TIMEOUT);
    check("tmo_state", 32'(o_state), 4);
    check("tmo_err", 32'(o_err), drop ? 0 : (1 << o));
    finish_release(o);
  endtask

  initial begin
    use_b = 1'b0;
    reset = 1'b0;
    m_request = '0;
    noise();
    step();
    step();
    check("reset_state_a", 32'(a_state), 0);
    check("reset_state_b", 32'(b_state), 0);
    check("reset_avail", 32'(a_m_available | b_m_available), 0);
    check("reset_err", 32'(a_m_error | b_m_error), 0);
    check("reset_slaves", 32'(a_s_bus_ready | a_s_data | a_s_valid), 0);
    reset = 1'b1;
    step();

    // Round-robin instance
    mode_cur = 1;
    m_last   = 3;
    run_txn(4'b0101, 2, 1'b1, 8'hA5, 8'h00, 0, 0);
    run_txn(4'b0101, 1, 1'b0, 8'h00, 8'h3C, 2, 0);
    run_timeout(4'b0010, 1, 1'b0);
    run_timeout(4'b0100, 3, 1'b1);
    run_txn(4'b1000, 0, 1'b1, 8'h5A, 8'hC3, 1, 3);
    for (int t = 0; t < 30; t++) begin
      int ab_sel;
      ab_sel = $urandom_range(0, 5);
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), $urandom_range(0, 4),
              (ab_sel == 0) ? 1 : (ab_sel == 1) ? 2 : 0);
    end
    m_request = '0;
    step();

    // Fixed-priority instance with three slaves
    use_b    = 1'b1;
    mode_cur = 0;
    reset    = 1'b0;
    step();
    reset    = 1'b1;
    m_last   = 3;
    step();
    run_txn(4'b1010, 0, 1'b1, 8'h81, 8'h18, 0, 0);
    run_txn(4'b1010, 2, 1'b0, 8'h7E, 8'hE7, 1, 0);
    run_txn(4'b1000, 1, 1'b1, 8'h0F, 8'hF0, 0, 0);
    run_txn(4'b0001, 3, 1'b1, 8'h00, 8'h00, 0, 0);
    for (int t = 0; t < 20; t++) begin
      int ab_sel;
      ab_sel = $urandom_range(0, 5);
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), $urandom_range(0, 4),
              (ab_sel == 0) ? 1 : (ab_sel == 1) ? 2 : 0);
    end
    m_request = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
